// File: rtl/clk_rate_pkg.sv
// Shared types and default rate table for the clock-rate detector.
// Default half-periods are the selectable divider's divide values plus one.
package clk_rate_pkg;

  typedef logic [1:0] rate_t;

  localparam int DEF_HALF0 = 5000;
  localparam int DEF_HALF1 = 50000;
  localparam int DEF_HALF2 = 500000;
  localparam int DEF_HALF3 = 5000000;
  localparam int DEF_TOL   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MEAS = 2'b01,
    ST_LOCK = 2'b10
  } state_t;

endpackage

// File: rtl/clk_rate_detector_sync_edge_det.sv
// Two-flop synchronizer for an asynchronous slow clock.
// Adds a one-cycle pulse on either transition of the synchronized level.
module sync_edge_det (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic async_i,
  output logic edge_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // synchronizer chain and previous-level register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign edge_o = sync2_q ^ prev_q;

endmodule

// File: rtl/clk_rate_detector.sv
// Measures the half-period of an asynchronous slow clock, decodes it back to
// the divider select code, reports lock once stable and flags a stalled input.
module clk_rate_detector
  import clk_rate_pkg::*;
#(
  parameter int CNT_W      = 24,
  parameter int HALF0      = DEF_HALF0,
  parameter int HALF1      = DEF_HALF1,
  parameter int HALF2      = DEF_HALF2,
  parameter int HALF3      = DEF_HALF3,
  parameter int TOL        = DEF_TOL,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_in,
  input  logic             clr,
  output logic [1:0]       rate_sel,
  output logic             locked,
  output logic             stalled,
  output logic [CNT_W-1:0] measured_half
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  // cnt reaching HALF3+TOL+1 is the stall point; detect one cycle ahead
  localparam logic [CNT_W-1:0] STALL_AT  = CNT_W'(HALF3 + TOL);
  localparam logic [MW-1:0]    LOCK_LAST = MW'(LOCK_COUNT - 1);
  localparam logic [MW-1:0]    MATCH_ONE = MW'(1);

  function automatic logic in_win(input logic [CNT_W-1:0] m, input int h);
    int mv;
    mv = int'(m);
    return (mv >= h - TOL) && (mv <= h + TOL);
  endfunction

  // returns {hit, code}
  function automatic logic [2:0] classify(input logic [CNT_W-1:0] m);
    logic [2:0] r;
    r = 3'b000;
    if (in_win(m, HALF0))      r = 3'b100;
    else if (in_win(m, HALF1)) r = 3'b101;
    else if (in_win(m, HALF2)) r = 3'b110;
    else if (in_win(m, HALF3)) r = 3'b111;
    else                       r = 3'b000;
    return r;
  endfunction

  logic             edge_s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] meas_q, meas_d;
  rate_t            rate_q, rate_d;
  rate_t            cand_q, cand_d;
  logic [MW-1:0]    match_q, match_d;
  logic             locked_q, locked_d;
  logic             stalled_q, stalled_d;
  logic [CNT_W-1:0] cnt_inc_s;
  logic [CNT_W-1:0] meas_new_s;
  logic [2:0]       cls_s;
  logic             hit_s;
  rate_t            code_s;

  sync_edge_det u_sync (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .async_i (clk_in),
    .edge_o  (edge_s)
  );

  assign cnt_inc_s  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
  assign meas_new_s = cnt_inc_s;
  assign cls_s      = classify(meas_new_s);
  assign hit_s      = cls_s[2];
  assign code_s     = cls_s[1:0];

  // next-state: clear, edge-driven classification, stall detection
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_inc_s;
    meas_d    = meas_q;
    rate_d    = rate_q;
    cand_d    = cand_q;
    match_d   = match_q;
    locked_d  = locked_q;
    stalled_d = stalled_q;
    if (clr) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      meas_d    = '0;
      rate_d    = 2'b00;
      cand_d    = 2'b00;
      match_d   = '0;
      locked_d  = 1'b0;
      stalled_d = 1'b0;
    end else if (edge_s) begin
      cnt_d     = '0;
      stalled_d = 1'b0;
      case (state_q)
        ST_IDLE: state_d = ST_MEAS;
        ST_MEAS: begin
          meas_d = meas_new_s;
          if (!hit_s) begin
            match_d = '0;
          end else if (code_s == cand_q) begin
            if (match_q == LOCK_LAST) begin
              state_d  = ST_LOCK;
              rate_d   = code_s;
              locked_d = 1'b1;
              match_d  = '0;
            end else begin
              match_d = match_q + MATCH_ONE;
            end
          end else begin
            cand_d = code_s;
            if (LOCK_COUNT == 1) begin
              state_d  = ST_LOCK;
              rate_d   = code_s;
              locked_d = 1'b1;
              match_d  = '0;
            end else begin
              match_d = MATCH_ONE;
            end
          end
        end
        ST_LOCK: begin
          meas_d = meas_new_s;
          if (hit_s && (code_s == rate_q)) begin
            state_d = ST_LOCK;
          end else begin
            locked_d = 1'b0;
            state_d  = ST_MEAS;
            if (!hit_s) begin
              match_d = '0;
            end else begin
              cand_d = code_s;
              if (LOCK_COUNT == 1) begin
                state_d  = ST_LOCK;
                rate_d   = code_s;
                locked_d = 1'b1;
                match_d  = '0;
              end else begin
                match_d = MATCH_ONE;
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (cnt_q == STALL_AT) begin
      stalled_d = 1'b1;
      locked_d  = 1'b0;
      state_d   = ST_IDLE;
      match_d   = '0;
    end else begin
      cnt_d = cnt_inc_s;
    end
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      meas_q    <= '0;
      rate_q    <= 2'b00;
      cand_q    <= 2'b00;
      match_q   <= '0;
      locked_q  <= 1'b0;
      stalled_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      meas_q    <= meas_d;
      rate_q    <= rate_d;
      cand_q    <= cand_d;
      match_q   <= match_d;
      locked_q  <= locked_d;
      stalled_q <= stalled_d;
    end
  end

  assign rate_sel      = rate_q;
  assign locked        = locked_q;
  assign stalled       = stalled_q;
  assign measured_half = meas_q;

endmodule

// File: tb/tb_clk_rate_detector.sv
// Directed bench: a small-table instance (HALF 50/100/200/400) plus one
// default-parameter instance for the full-scale 5000-cycle case.
module tb_clk_rate_detector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clk_in_a = 1'b0;
  logic        clr_a = 1'b0;
  logic [1:0]  rate_a;
  logic        locked_a;
  logic        stalled_a;
  logic [23:0] meas_a;

  logic        clk_in_b = 1'b0;
  logic        clr_b = 1'b0;
  logic [1:0]  rate_b;
  logic        locked_b;
  logic        stalled_b;
  logic [23:0] meas_b;

  int n_cmp = 0;
  int n_bad = 0;
  int since = 0;

  clk_rate_detector #(
    .CNT_W(24), .HALF0(50), .HALF1(100), .HALF2(200), .HALF3(400),
    .TOL(2), .LOCK_COUNT(4)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .clk_in(clk_in_a), .clr(clr_a),
    .rate_sel(rate_a), .locked(locked_a), .stalled(stalled_a),
    .measured_half(meas_a)
  );

  clk_rate_detector u_def (
    .clk(clk), .rst_n(rst_n), .clk_in(clk_in_b), .clr(clr_b),
    .rate_sel(rate_b), .locked(locked_b), .stalled(stalled_b),
    .measured_half(meas_b)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // toggle clk_in so that it sits n cycles after the previous toggle
  task automatic gap(input int n);
    if (n > since) repeat (n - since) @(posedge clk);
    #1 clk_in_a = ~clk_in_a;
    since = 0;
  endtask

  // let the last toggle pass the synchronizer and reach the outputs
  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
    since += 3;
  endtask

  task automatic pulse_clr();
    clr_a = 1'b1;
    @(posedge clk);
    #1 clr_a = 1'b0;
    since += 1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #3;
    chk("rst_locked", {31'd0, locked_a}, 32'd0);
    chk("rst_stalled", {31'd0, stalled_a}, 32'd0);
    chk("rst_rate", {30'd0, rate_a}, 32'd0);
    chk("rst_meas", {8'd0, meas_a}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    since = 0;

    // 1: steady 50-cycle halves lock on code 00 at the 5th edge
    repeat (4) gap(50);
    settle();
    chk("t1_pre_locked", {31'd0, locked_a}, 32'd0);
    chk("t1_pre_meas", {8'd0, meas_a}, 32'd50);
    gap(50);
    settle();
    chk("t1_locked", {31'd0, locked_a}, 32'd1);
    chk("t1_rate", {30'd0, rate_a}, 32'd0);
    chk("t1_meas", {8'd0, meas_a}, 32'd50);

    // 2: rate change to 200 drops lock, relocks on 10 after 4 halves
    gap(200);
    settle();
    chk("t2_drop_locked", {31'd0, locked_a}, 32'd0);
    chk("t2_drop_meas", {8'd0, meas_a}, 32'd200);
    chk("t2_drop_rate_hold", {30'd0, rate_a}, 32'd0);
    repeat (2) gap(200);
    settle();
    chk("t2_mid_locked", {31'd0, locked_a}, 32'd0);
    gap(200);
    settle();
    chk("t2_locked", {31'd0, locked_a}, 32'd1);
    chk("t2_rate", {30'd0, rate_a}, 32'd2);

    // 3a: tolerance edges 48/52/50/49 lock on 00
    pulse_clr();
    chk("t3_clr_locked", {31'd0, locked_a}, 32'd0);
    chk("t3_clr_rate", {30'd0, rate_a}, 32'd0);
    chk("t3_clr_meas", {8'd0, meas_a}, 32'd0);
    gap(50);
    gap(48);
    gap(52);
    gap(50);
    gap(49);
    settle();
    chk("t3a_locked", {31'd0, locked_a}, 32'd1);
    chk("t3a_rate", {30'd0, rate_a}, 32'd0);
    chk("t3a_meas", {8'd0, meas_a}, 32'd49);

    // 3b: 53 is outside the window and restarts the count
    pulse_clr();
    gap(50);
    gap(50);
    gap(50);
    gap(53);
    gap(50);
    settle();
    chk("t3b_locked", {31'd0, locked_a}, 32'd0);
    chk("t3b_meas", {8'd0, meas_a}, 32'd50);
    repeat (2) gap(50);
    settle();
    chk("t3b_cnt3_locked", {31'd0, locked_a}, 32'd0);
    gap(50);
    settle();
    chk("t3b_relock", {31'd0, locked_a}, 32'd1);

    // 4: lock at 01, then stall exactly 403 cycles after the last edge
    gap(100);
    settle();
    chk("t4_drop_locked", {31'd0, locked_a}, 32'd0);
    chk("t4_drop_rate_hold", {30'd0, rate_a}, 32'd0);
    repeat (3) gap(100);
    settle();
    chk("t4_locked", {31'd0, locked_a}, 32'd1);
    chk("t4_rate", {30'd0, rate_a}, 32'd1);
    repeat (402) @(posedge clk);
    #1 since += 402;
    chk("t4_prestall_stalled", {31'd0, stalled_a}, 32'd0);
    chk("t4_prestall_locked", {31'd0, locked_a}, 32'd1);
    @(posedge clk);
    #1 since += 1;
    chk("t4_stalled", {31'd0, stalled_a}, 32'd1);
    chk("t4_stall_locked", {31'd0, locked_a}, 32'd0);
    gap(100);
    settle();
    chk("t4_unstall", {31'd0, stalled_a}, 32'd0);
    chk("t4_unstall_locked", {31'd0, locked_a}, 32'd0);
    repeat (3) gap(100);
    settle();
    chk("t4_relock_early", {31'd0, locked_a}, 32'd0);
    gap(100);
    settle();
    chk("t4_relock", {31'd0, locked_a}, 32'd1);
    chk("t4_relock_rate", {30'd0, rate_a}, 32'd1);
    chk("t4_relock_meas", {8'd0, meas_a}, 32'd100);

    // 5: alternating classes never lock
    pulse_clr();
    gap(50);
    for (int i = 0; i < 20; i++) begin
      gap((i % 2 == 0) ? 50 : 100);
      settle();
      chk("t5_meas", {8'd0, meas_a}, (i % 2 == 0) ? 32'd50 : 32'd100);
      chk("t5_locked", {31'd0, locked_a}, 32'd0);
    end

    // 6a: async reset while locked clears outputs mid-cycle
    pulse_clr();
    repeat (5) gap(200);
    settle();
    chk("t6_prelock", {31'd0, locked_a}, 32'd1);
    chk("t6_prerate", {30'd0, rate_a}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_locked", {31'd0, locked_a}, 32'd0);
    chk("t6_rst_rate", {30'd0, rate_a}, 32'd0);
    chk("t6_rst_meas", {8'd0, meas_a}, 32'd0);
    chk("t6_rst_stalled", {31'd0, stalled_a}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 since = 5;

    // 6b: clr coinciding with the edge wins; the next edge is an IDLE edge
    clk_in_a = ~clk_in_a;
    repeat (2) @(posedge clk);
    #1 clr_a = 1'b1;
    @(posedge clk);
    #1 clr_a = 1'b0;
    since = 3;
    chk("t6_clr_meas", {8'd0, meas_a}, 32'd0);
    chk("t6_clr_locked", {31'd0, locked_a}, 32'd0);
    gap(50);
    settle();
    chk("t6_idle_edge_meas", {8'd0, meas_a}, 32'd0);
    gap(50);
    settle();
    chk("t6_first_meas", {8'd0, meas_a}, 32'd50);

    // 1b: default parameters, 5000-cycle halves
    repeat (5) begin
      repeat (5000) @(posedge clk);
      #1 clk_in_b = ~clk_in_b;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("t1b_locked", {31'd0, locked_b}, 32'd1);
    chk("t1b_rate", {30'd0, rate_b}, 32'd0);
    chk("t1b_meas", {8'd0, meas_b}, 32'd5000);
    chk("t1b_stalled", {31'd0, stalled_b}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
